forwarding_control: RTL and testbench
=====================================

# forwarding_control

Pipeline hazard tracker that drives the select inputs of the execute-stage operand forwarding mux. It records the destination register, write flag and load flag of the instructions in the execute (E) and memory (M) stages. From these and the source registers of the instruction in decode (D), it produces registered select signals One_A/One_B/Two_A/Two_B and a load-use stall. It sits between the decode stage and the forwarding mux; the mux's One input is the E→M result and its Two input is the M→W result.

## Interface
- REG_BITS, 4, register address width (16 architectural registers)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  D holds a real instruction
- id_src_a, id_src_b  in  REG_BITS  D source register addresses
- id_use_a, id_use_b  in  1  corresponding source is actually read
- id_dest  in  REG_BITS  D destination register
- id_wr  in  1  D writes id_dest
- id_load  in  1  D is a load (result available only at end of M)
- flush  in  1  squash D (taken branch); D enters E as a bubble
- One_A, One_B  out  1  registered; 1 = operand A/B from One (instruction one ahead)
- Two_A, Two_B  out  1  registered; 1 = operand A/B from Two (instruction two ahead)
- stall  out  1  combinational; 1 = hold PC/D, insert bubble into E

## Operation
- Tracking registers:
  - E slot: e_valid, e_dest, e_wr, e_load.
  - M slot: m_valid, m_dest, m_wr.
- Match definitions:
  - Match E: e_valid & e_wr & e_dest==src.
  - Match M: m_valid & m_wr & m_dest==src.
- stall = id_valid & e_valid & e_load & e_wr & ((id_use_a & e_dest==id_src_a) | (id_use_b & e_dest==id_src_b)).
- stall is suppressed when flush=1, because a flushed D needs no operands.
- Advance, every cycle:
  - M slot <= E slot.
  - E slot <= D if id_valid & !stall & !flush; otherwise E slot <= bubble (valid=0).
- Select computation, per operand X (A/B), registered on the same edge that moves D into E:
  - One_X <= advancing & use_X & Match E(src_X).
  - Two_X <= advancing & use_X & !Match E(src_X) & Match M(src_X).
  - advancing = id_valid & !stall & !flush.
- Priority: One over Two, because the newest writer wins. One_X and Two_X are never 1 together.
- On a bubble, all four selects become 0 (register-file path).
- E-load matches never assert One_X. That case always stalls, so after the stall the load is in M and resolves via Two.
- No state machine beyond the two shift slots. The stall lasts exactly one cycle per load-use hazard, because the load leaves E on the stall cycle.

## Timing
- Reset (rst=1 at edge): e_valid=m_valid=0; One_A=One_B=Two_A=Two_B=0. stall reads 0 the cycle after reset.
- Select latency: 1 cycle. Selects are valid in the cycle the instruction occupies E, aligned with the One/Two data at the mux.
- stall is combinational from D inputs and the E slot, within the same cycle.
- rst overrides flush and stall. rst asserted mid-hazard clears the slots, and stall drops next cycle.
- flush and stall in the same cycle: flush wins, stall=0, and E gets a bubble.
- Back-to-back writers to the same register (E and M both match): One selected.
- Both operands hitting the same source: both A and B selects asserted identically.

## Configuration
- FWD_R0_ZERO_EN defined:
  - Register 0 is hardwired zero.
  - Any slot with dest==0 never matches, so no forward and no stall for r0.
- FWD_R0_ZERO_EN undefined: r0 is an ordinary register and matches like any other.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 → all selects 0, stall 0; first post-reset instruction reading r3 → no forward.
- ALU chain: ADD r3 (wr) then ADD reading r3 on A → One_A=1 in the consumer's E cycle; with one independent instruction between → Two_A=1, One_A=0.
- Double writer: r5 written in consecutive instructions, then read on B → One_B=1, Two_B=0.
- Load-use: LOAD r2 then instruction reading r2 → stall=1 for exactly one cycle, bubble in E (selects 0), then Two_A=1.
- Flush during load-use: flush=1 in the stall cycle → stall=0, E bubble, no selects asserted.
- r0: writer to r0 then reader of r0 → with FWD_R0_ZERO_EN, One_A=0; without it, One_A=1.

Source files
------------

// File: rtl/forwarding_control.sv
// Purpose : operand-forwarding hazard tracker; drives One/Two selects of the E-stage mux and a load-use stall.
// Latency : selects registered, 1 cycle (valid while the instruction sits in E); stall combinational, same cycle.
// Backpres: stall holds PC/D for exactly one cycle per load-use hazard; flush squashes D and suppresses stall.
//
// Optional feature macro: FWD_R0_ZERO_EN -- when defined, r0 is hardwired zero and never forwards or stalls.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   id_valid                      D holds a real instruction
//   id_src_a/b, id_use_a/b        D source registers and whether each is actually read
//   id_dest, id_wr, id_load       D destination, write flag, load flag
//   flush                         squash D; it enters E as a bubble
//   One_A/B, Two_A/B              registered mux selects (One = E->M result, Two = M->W result)
//   stall                         combinational load-use stall
module forwarding_control #(
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_src_a,
    input  logic [REG_BITS-1:0] id_src_b,
    input  logic                id_use_a,
    input  logic                id_use_b,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_wr,
    input  logic                id_load,
    input  logic                flush,
    output logic                One_A,
    output logic                One_B,
    output logic                Two_A,
    output logic                Two_B,
    output logic                stall
);

    // E slot: instruction one ahead of D
    logic                e_valid;
    logic [REG_BITS-1:0] e_dest;
    logic                e_wr;
    logic                e_load;
    // M slot: instruction two ahead of D
    logic                m_valid;
    logic [REG_BITS-1:0] m_dest;
    logic                m_wr;

    // A slot is "live" when it will actually produce a forwardable register value.
    logic e_live;
    logic m_live;
`ifdef FWD_R0_ZERO_EN
    // r0 reads as constant zero, so a write to it is never a dependency.
    assign e_live = e_valid & e_wr & (e_dest != '0);
    assign m_live = m_valid & m_wr & (m_dest != '0);
`else
    assign e_live = e_valid & e_wr;
    assign m_live = m_valid & m_wr;
`endif

    logic match_e_a, match_e_b, match_m_a, match_m_b;
    assign match_e_a = e_live & (e_dest == id_src_a);
    assign match_e_b = e_live & (e_dest == id_src_b);
    assign match_m_a = m_live & (m_dest == id_src_a);
    assign match_m_b = m_live & (m_dest == id_src_b);

    // Load result exists only at the end of M, so a consumer directly behind a load waits one cycle.
    // A flushed D needs no operands, so flush masks the stall.
    logic load_use;
    assign load_use = id_valid & e_load &
                      ((id_use_a & match_e_a) | (id_use_b & match_e_b));
    assign stall    = load_use & ~flush;

    logic advancing;
    assign advancing = id_valid & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_dest  <= '0;
            e_wr    <= 1'b0;
            e_load  <= 1'b0;
            m_valid <= 1'b0;
            m_dest  <= '0;
            m_wr    <= 1'b0;
            One_A   <= 1'b0;
            One_B   <= 1'b0;
            Two_A   <= 1'b0;
            Two_B   <= 1'b0;
        end else begin
            // The load leaves E on the stall cycle, which bounds the stall to one cycle.
            m_valid <= e_valid;
            m_dest  <= e_dest;
            m_wr    <= e_wr;
            e_valid <= advancing;
            e_dest  <= id_dest;
            e_wr    <= id_wr;
            e_load  <= id_load;
            // Newest writer wins: One takes priority, Two only when E does not match.
            // An E-resident load never drives One; that case has stalled and resolves via Two.
            One_A   <= advancing & id_use_a & match_e_a & ~e_load;
            One_B   <= advancing & id_use_b & match_e_b & ~e_load;
            Two_A   <= advancing & id_use_a & ~match_e_a & match_m_a;
            Two_B   <= advancing & id_use_b & ~match_e_b & match_m_b;
        end
    end

endmodule

// File: tb/tb_forwarding_control.sv
module tb_forwarding_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src_a, id_src_b, id_dest;
    logic       id_use_a, id_use_b, id_wr, id_load, flush;
    logic       One_A, One_B, Two_A, Two_B, stall;

    forwarding_control #(.REG_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .id_src_a (id_src_a),
        .id_src_b (id_src_b),
        .id_use_a (id_use_a),
        .id_use_b (id_use_b),
        .id_dest  (id_dest),
        .id_wr    (id_wr),
        .id_load  (id_load),
        .flush    (flush),
        .One_A    (One_A),
        .One_B    (One_B),
        .Two_A    (Two_A),
        .Two_B    (Two_B),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    // Expected observation for one cycle: {One_A, One_B, Two_A, Two_B, stall}
    typedef struct {
        string      name;
        logic [4:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef FWD_R0_ZERO_EN
    localparam logic [4:0] R0_SEL   = 5'b00000;
    localparam logic       R0_STALL = 1'b0;
`else
    localparam logic [4:0] R0_SEL   = 5'b10000;
    localparam logic       R0_STALL = 1'b1;
`endif

    // Drive one cycle of D-stage inputs just after the rising edge and queue what the
    // outputs must show during this cycle (selects from the previous edge, stall from these inputs).
    task automatic step(input string name, input logic r, input logic fl, input logic v,
                        input logic [3:0] sa, input logic ua, input logic [3:0] sb, input logic ub,
                        input logic [3:0] d, input logic wr, input logic ld, input logic [4:0] exp_vec);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        flush    = fl;
        id_valid = v;
        id_src_a = sa;
        id_use_a = ua;
        id_src_b = sb;
        id_use_b = ub;
        id_dest  = d;
        id_wr    = wr;
        id_load  = ld;
        e.name   = name;
        e.vec    = exp_vec;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a pending expectation, compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] got;
            e   = exp_q.pop_front();
            got = {One_A, One_B, Two_A, Two_B, stall};
            n_checks++;
            if (got !== e.vec) begin
                n_errors++;
                $display("FAIL %s: got {OneA,OneB,TwoA,TwoB,stall}=%b expected %b", e.name, got, e.vec);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; id_valid = 1'b1;
        id_src_a = 4'd3; id_use_a = 1'b1; id_src_b = 4'd0; id_use_b = 1'b0;
        id_dest = 4'd3; id_wr = 1'b1; id_load = 1'b0;

        //    name              rst fl  v  sa   ua  sb   ub  dest wr ld  {OA,OB,TA,TB,st}
        step("reset_1",         1, 0, 1, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0, 5'b00000);
        step("reset_2",         1, 0, 1, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0, 5'b00000);
        step("post_reset_r3",   0, 0, 1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 5'b00000);
        step("alu_writer_r3",   0, 0, 1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 5'b00000);
        step("alu_reader_r3",   0, 0, 1, 4'd3, 1, 4'd6, 1, 4'd7, 1, 0, 5'b00000);
        step("one_a_chain",     0, 0, 1, 4'd8, 1, 4'd9, 1, 4'd10,1, 0, 5'b10000);
        step("reader_r7_gap",   0, 0, 1, 4'd7, 1, 4'd11,0, 4'd12,1, 0, 5'b00000);
        step("two_a_gap",       0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 5'b00100);
        step("dbl_writer_2",    0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 5'b00000);
        step("reader_r5_b",     0, 0, 1, 4'd1, 1, 4'd5, 1, 4'd6, 1, 0, 5'b00000);
        step("dbl_writer_one_b",0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1, 5'b01000);
        step("load_use_stall",  0, 0, 1, 4'd2, 1, 4'd3, 1, 4'd8, 1, 0, 5'b00001);
        step("load_use_bubble", 0, 0, 1, 4'd2, 1, 4'd3, 1, 4'd8, 1, 0, 5'b00000);
        step("load_use_two_a",  0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 5'b00100);
        step("load_r9",         0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 1, 5'b00000);
        step("flush_over_stall",0, 1, 1, 4'd9, 1, 4'd9, 1, 4'd1, 1, 0, 5'b00000);
        step("flush_bubble",    0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd11,1, 0, 5'b00000);
        step("same_src_ab",     0, 0, 1, 4'd11,1, 4'd11,1, 4'd12,1, 0, 5'b00000);
        step("same_src_one_ab", 0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 5'b11000);
        step("rst_mid_hazard",  1, 0, 1, 4'd4, 1, 4'd0, 0, 4'd5, 1, 0, 5'b00001);
        step("after_rst_hazard",0, 0, 1, 4'd4, 1, 4'd0, 0, 4'd5, 1, 0, 5'b00000);
        step("r0_writer",       0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 5'b00000);
        step("r0_reader",       0, 0, 1, 4'd0, 1, 4'd0, 0, 4'd3, 1, 0, 5'b00000);
        step("r0_select",       0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, R0_SEL);
        step("r0_load",         0, 0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 1, 5'b00000);
        step("r0_load_use",     0, 0, 1, 4'd0, 1, 4'd0, 0, 4'd6, 1, 0, {4'b0000, R0_STALL});
        step("r0_after",        0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 5'b00000);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
